// File: rtl/reg_file_read_stage_pkg.sv
// Shared types for the RV32 register-file read stage: register indices,
// the decode-to-read-stage request bundle and default widths.
package reg_file_inc;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REGISTER_X0 = 5'd0;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } reg_file_read_params_t;

endpackage

// File: rtl/reg_file_read_stage_scoreboard.sv
// Per-register pending-write tracker; set on issue, cleared on write-back (set wins).
// Hazard is combinational from current pending bits and this cycle's write-back.
module reg_scoreboard
  import reg_file_inc::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  input  logic     rd_we,
  input  logic     issue,
  input  logic     wb_valid,
  input  reg_idx_t wb_rd,
  output logic     hazard
);

  // Bit 0 exists only so any 5-bit index is in range; it is held at zero.
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                rs1_blk;
  logic                rs2_blk;
  logic                rd_blk;

  always_comb begin
    pending_nxt = pending;
    if (wb_valid && (wb_rd != REGISTER_X0)) pending_nxt[wb_rd] = 1'b0;
    if (issue && rd_we && (rd != REGISTER_X0)) pending_nxt[rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // A write-back landing this cycle releases its register immediately.
  assign rs1_blk = (rs1 != REGISTER_X0) && pending[rs1] && !(wb_valid && (wb_rd == rs1));
  assign rs2_blk = (rs2 != REGISTER_X0) && pending[rs2] && !(wb_valid && (wb_rd == rs2));
  assign rd_blk  = rd_we && (rd != REGISTER_X0) && pending[rd] && !(wb_valid && (wb_rd == rd));

  assign hazard = rs1_blk | rs2_blk | rd_blk;

endmodule

// File: rtl/reg_file_read_stage.sv
// RV32 register-file read with write-back bypass and RAW/WAW stall; one-cycle latency.
// One-entry output register: in_ready drops on hazard or when the entry is held by !out_ready.
module reg_file_read_stage
  import reg_file_inc::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  reg_file_read_params_t in_params,
  input  logic                  in_rd_we,
  input  logic                  wb_valid,
  input  reg_idx_t              wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output reg_idx_t              out_rd,
  output logic                  out_rd_we
);

  logic [XLEN-1:0] regs [1:NUM_REGS-1];
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            hazard;
  logic            accept;
  logic            rd_we_eff;

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (in_params.rs1),
    .rs2      (in_params.rs2),
    .rd       (in_params.rd),
    .rd_we    (in_rd_we),
    .issue    (accept),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .hazard   (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_valid && (wb_rd != REGISTER_X0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (in_params.rs1 != REGISTER_X0)
      rs1_data = (wb_valid && (wb_rd == in_params.rs1)) ? wb_data : regs[in_params.rs1];
  end

  always_comb begin
    rs2_data = '0;
    if (in_params.rs2 != REGISTER_X0)
      rs2_data = (wb_valid && (wb_rd == in_params.rs2)) ? wb_data : regs[in_params.rs2];
  end

  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign rd_we_eff = in_rd_we && (in_params.rd != REGISTER_X0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= REGISTER_X0;
      out_rd_we    <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_rd       <= in_params.rd;
      out_rd_we    <= rd_we_eff;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_read_stage.sv
// Directed bench for reg_file_read_stage: stimulus pushes expected operands,
// an independent monitor pops and compares on every output handshake.
module tb_reg_file_read_stage;
  import reg_file_inc::*;

  typedef struct {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_we;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  reg_file_read_params_t in_params = '0;
  logic                  in_rd_we = 1'b0;
  logic                  wb_valid = 1'b0;
  reg_idx_t              wb_rd = '0;
  logic [31:0]           wb_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [31:0]           out_rs1_data;
  logic [31:0]           out_rs2_data;
  reg_idx_t              out_rd;
  logic                  out_rd_we;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t nx;

  reg_file_read_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_params    (in_params),
    .in_rd_we     (in_rd_we),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every consumed output entry against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rs1 0x%08h with empty queue at %0t", out_rs1_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_rs1_data", out_rs1_data, e.rs1_data);
        chk("out_rs2_data", out_rs2_data, e.rs2_data);
        chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, e.rd_we});
      end
    end
  end

  task automatic set_req(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
    in_valid      = v;
    in_params.rs1 = rs1;
    in_params.rs2 = rs2;
    in_params.rd  = rd;
    in_rd_we      = we;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  task automatic set_exp(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we);
    nx.rs1_data = a;
    nx.rs2_data = b;
    nx.rd       = rd;
    nx.rd_we    = we;
  endtask

  // One clock: check in_ready mid-cycle, record the expected entry if acceptance is due.
  task automatic cyc(input string name, input logic exp_rdy);
    @(negedge clk);
    chk(name, {31'd0, in_ready}, {31'd0, exp_rdy});
    if (in_valid && exp_rdy) exp_q.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_rs1", out_rs1_data, 32'd0);
    chk("rst_out_rd_we", {31'd0, out_rd_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write x5, then read it back from storage
    set_wb(1, 5'd5, 32'h1234_5678);
    cyc("idle_wb5_ready", 1'b1);
    set_wb(0, 0, 0);
    set_req(1, 5'd5, 5'd0, 5'd1, 0); set_exp(32'h1234_5678, 32'd0, 5'd1, 0);
    cyc("rd_x5_ready", 1'b1);

    // Same-cycle bypass of x7, back to back with previous accept
    set_wb(1, 5'd7, 32'hDEAD_BEEF);
    set_req(1, 5'd7, 5'd5, 5'd0, 0); set_exp(32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 0);
    cyc("bypass_x7_ready", 1'b1);
    set_wb(0, 0, 0);

    // RAW on x3
    set_req(1, 5'd0, 5'd0, 5'd3, 1); set_exp(32'd0, 32'd0, 5'd3, 1);
    cyc("issue_rd3_ready", 1'b1);
    set_req(1, 5'd0, 5'd3, 5'd0, 0);
    for (int i = 0; i < 3; i++) cyc("raw_x3_stall", 1'b0);
    set_wb(1, 5'd3, 32'h42); set_exp(32'd0, 32'h42, 5'd0, 0);
    cyc("raw_x3_release", 1'b1);
    set_wb(0, 0, 0);

    // WAW on x9 with set-wins
    set_req(1, 5'd0, 5'd0, 5'd9, 1); set_exp(32'd0, 32'd0, 5'd9, 1);
    cyc("issue_rd9_ready", 1'b1);
    set_wb(1, 5'd9, 32'h99);
    cyc("waw_rd9_wb_same_cycle", 1'b1);
    set_wb(0, 0, 0);
    set_req(1, 5'd9, 5'd0, 5'd0, 0);
    for (int i = 0; i < 2; i++) cyc("set_wins_x9_stall", 1'b0);
    set_wb(1, 5'd9, 32'h77); set_exp(32'h77, 32'd0, 5'd0, 0);
    cyc("x9_release", 1'b1);
    set_wb(0, 0, 0);
    set_req(0, 0, 0, 0, 0);
    cyc("idle_drain", 1'b1);

    // Backpressure: hold entry A for 3 cycles, B waits
    out_ready = 1'b0;
    set_req(1, 5'd5, 5'd7, 5'd2, 0); set_exp(32'h1234_5678, 32'hDEAD_BEEF, 5'd2, 0);
    cyc("bp_first_ready", 1'b1);
    set_req(1, 5'd3, 5'd9, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("bp_in_ready_low", 1'b0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rs1_stable", out_rs1_data, 32'h1234_5678);
      chk("bp_rs2_stable", out_rs2_data, 32'hDEAD_BEEF);
      chk("bp_rd_stable", {27'd0, out_rd}, 32'd2);
    end
    out_ready = 1'b1;
    set_exp(32'h42, 32'h77, 5'd0, 0);
    cyc("bp_release_ready", 1'b1);

    // x0: write dropped, no bypass, no pending bit, rd_we squashed
    set_wb(1, 5'd0, 32'hFFFF_FFFF);
    set_req(1, 5'd0, 5'd0, 5'd0, 1); set_exp(32'd0, 32'd0, 5'd0, 0);
    cyc("x0_issue_ready", 1'b1);
    set_wb(0, 0, 0);
    set_req(1, 5'd0, 5'd5, 5'd0, 1); set_exp(32'd0, 32'h1234_5678, 5'd0, 0);
    cyc("x0_no_pending_ready", 1'b1);
    set_req(0, 0, 0, 0, 0);
    cyc("idle_x0", 1'b1);

    // Reset mid-operation with a held entry and a pending x4
    out_ready = 1'b0;
    set_req(1, 5'd7, 5'd0, 5'd4, 1); set_exp(32'hDEAD_BEEF, 32'd0, 5'd4, 1);
    cyc("pre_reset_issue", 1'b1);
    set_req(0, 0, 0, 0, 0);
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("reset_out_rs1", out_rs1_data, 32'd0);
    chk("reset_out_rd", {27'd0, out_rd}, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_req(1, 5'd4, 5'd7, 5'd0, 0); set_exp(32'd0, 32'd0, 5'd0, 0);
    cyc("post_reset_no_pending", 1'b1);
    set_req(0, 0, 0, 0, 0);
    cyc("idle_end", 1'b1);
    cyc("idle_end2", 1'b1);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
